// File: rtl/mem_bridge.sv
// mem_bridge
// ----------
// Bridges an upstream request/response port to a memory port. Requests pass
// through a small FIFO, so nothing on up_req_* reaches mem_req_* in the same
// cycle. Memory responses collect in a response FIFO before they go back
// upstream.
//
// The number of response-expecting requests that can be in flight is limited
// by credits. A read is always response-expecting. A write is
// response-expecting only when WRITE_RESP=1. The bridge issues such a request
// only while outstanding + response-FIFO occupancy < RESP_DEPTH. Because of
// this, every answer the memory returns has a guaranteed slot in the response
// FIFO.
//
// Handshake semantics (every channel): a transfer happens on a rising clk edge
// where valid and ready are both 1. A source that raises valid holds valid and
// its payload stable until that transfer.
//
// Ports
//   clk, rst              : clock (rising edge); asynchronous active-low reset
//   up_req_*              : upstream request (addr/we/data/be, valid/ready)
//   up_resp_*             : upstream response (data, valid/ready)
//   mem_req_*             : memory request (addr/we/data/be, valid/ready)
//   mem_resp_*            : memory response (data, valid/ready)
//   outstanding           : issued response-expecting requests not yet answered
//   err                   : sticky flag; set when a response arrives with
//                           nothing outstanding

module mem_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REQ_DEPTH  = 2,
  parameter int RESP_DEPTH = 4,
  parameter int WRITE_RESP = 0
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic [ADDR_WIDTH-1:0]         up_req_addr,
  input  logic                          up_req_we,
  input  logic [DATA_WIDTH-1:0]         up_req_data,
  input  logic [DATA_WIDTH/8-1:0]       up_req_be,
  input  logic                          up_req_valid,
  output logic                          up_req_ready,

  output logic [DATA_WIDTH-1:0]         up_resp_data,
  output logic                          up_resp_valid,
  input  logic                          up_resp_ready,

  output logic [ADDR_WIDTH-1:0]         mem_req_addr,
  output logic                          mem_req_we,
  output logic [DATA_WIDTH-1:0]         mem_req_data,
  output logic [DATA_WIDTH/8-1:0]       mem_req_be,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,

  input  logic [DATA_WIDTH-1:0]         mem_resp_data,
  input  logic                          mem_resp_valid,
  output logic                          mem_resp_ready,

  output logic [$clog2(RESP_DEPTH):0]   outstanding,
  output logic                          err
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int QA    = $clog2(REQ_DEPTH);
  localparam int SA    = $clog2(RESP_DEPTH);
  localparam int OW    = SA + 1;
  localparam int SUM_W = OW + 1;

  localparam logic [QA:0]      Q_ONE        = (QA+1)'(1);
  localparam logic [SA:0]      S_ONE        = (SA+1)'(1);
  localparam logic [OW-1:0]    O_ONE        = OW'(1);
  localparam logic [SUM_W-1:0] CREDIT_LIMIT = SUM_W'(RESP_DEPTH);

  // ---------------------------------------------------------------------------
  // Request FIFO
  // The pointers carry one extra wrap bit. With that bit, full and empty can
  // be told apart without a separate counter.
  // ---------------------------------------------------------------------------
  logic [QA:0]            q_wr_ptr;
  logic [QA:0]            q_rd_ptr;
  logic [ADDR_WIDTH-1:0]  q_addr [REQ_DEPTH];
  logic                   q_we   [REQ_DEPTH];
  logic [DATA_WIDTH-1:0]  q_data [REQ_DEPTH];
  logic [BE_W-1:0]        q_be   [REQ_DEPTH];

  logic q_empty;
  logic q_full;
  logic q_push;
  logic q_pop;
  logic head_rx;
  logic credit_ok;
  logic issue_rx;

  assign q_empty = (q_wr_ptr == q_rd_ptr);
  assign q_full  = (q_wr_ptr[QA] != q_rd_ptr[QA]) &&
                   (q_wr_ptr[QA-1:0] == q_rd_ptr[QA-1:0]);

  // Ready depends only on fullness, not on a same-cycle pop. A full FIFO
  // therefore never accepts a push, even while it is draining.
  assign up_req_ready = rst & ~q_full;
  assign q_push       = up_req_valid & up_req_ready;

  assign mem_req_addr = q_addr[q_rd_ptr[QA-1:0]];
  assign mem_req_we   = q_we[q_rd_ptr[QA-1:0]];
  assign mem_req_data = q_data[q_rd_ptr[QA-1:0]];
  assign mem_req_be   = q_be[q_rd_ptr[QA-1:0]];

  assign head_rx = mem_req_we ? (WRITE_RESP != 0) : 1'b1;

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  logic [SA:0]            s_wr_ptr;
  logic [SA:0]            s_rd_ptr;
  logic [DATA_WIDTH-1:0]  s_data [RESP_DEPTH];
  logic [OW-1:0]          s_count;

  logic s_empty;
  logic s_full;
  logic s_push;
  logic s_pop;
  logic resp_xfer;
  logic resp_ok;
  logic resp_stray;

  assign s_empty = (s_wr_ptr == s_rd_ptr);
  assign s_full  = (s_wr_ptr[SA] != s_rd_ptr[SA]) &&
                   (s_wr_ptr[SA-1:0] == s_rd_ptr[SA-1:0]);
  assign s_count = s_wr_ptr - s_rd_ptr;

  assign mem_resp_ready = rst & ~s_full;
  assign resp_xfer      = mem_resp_valid & mem_resp_ready;
  // A response with nothing outstanding has no request to answer. It is
  // dropped and flagged instead of being queued.
  assign resp_ok        = resp_xfer & (outstanding != '0);
  assign resp_stray     = resp_xfer & (outstanding == '0);
  assign s_push         = resp_ok;

  assign up_resp_valid  = rst & ~s_empty;
  assign up_resp_data   = s_data[s_rd_ptr[SA-1:0]];
  assign s_pop          = up_resp_valid & up_resp_ready;

  // ---------------------------------------------------------------------------
  // Credit check and issue
  // Once the head is offered, the check cannot fall back to 0 before the
  // transfer. A returning response moves one unit from outstanding into the
  // FIFO occupancy, so the sum stays the same. An upstream pop only lowers
  // the sum. This keeps mem_req_valid stable while the head waits.
  // ---------------------------------------------------------------------------
  assign credit_ok     = ({1'b0, outstanding} + {1'b0, s_count}) < CREDIT_LIMIT;
  assign mem_req_valid = rst & ~q_empty & (~head_rx | credit_ok);
  assign q_pop         = mem_req_valid & mem_req_ready;
  assign issue_rx      = q_pop & head_rx;

  // ---------------------------------------------------------------------------
  // Storage arrays. They are not reset; the pointers alone define validity.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (q_push) begin
      q_addr[q_wr_ptr[QA-1:0]] <= up_req_addr;
      q_we[q_wr_ptr[QA-1:0]]   <= up_req_we;
      q_data[q_wr_ptr[QA-1:0]] <= up_req_data;
      q_be[q_wr_ptr[QA-1:0]]   <= up_req_be;
    end
    if (s_push) begin
      s_data[s_wr_ptr[SA-1:0]] <= mem_resp_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, outstanding counter and error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_wr_ptr    <= '0;
      q_rd_ptr    <= '0;
      s_wr_ptr    <= '0;
      s_rd_ptr    <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (q_push) q_wr_ptr <= q_wr_ptr + Q_ONE;
      if (q_pop)  q_rd_ptr <= q_rd_ptr + Q_ONE;
      if (s_push) s_wr_ptr <= s_wr_ptr + S_ONE;
      if (s_pop)  s_rd_ptr <= s_rd_ptr + S_ONE;

      // An issue and an answer in the same cycle cancel each other out.
      case ({issue_rx, resp_ok})
        2'b10:   outstanding <= outstanding + O_ONE;
        2'b01:   outstanding <= outstanding - O_ONE;
        default: outstanding <= outstanding;
      endcase

      if (resp_stray) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
module tb_mem_bridge;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (WRITE_RESP = 0)
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_be = '0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] resp_data;
  logic        resp_valid;
  logic        resp_rdy = 1'b0;
  logic [31:0] mreq_addr;
  logic        mreq_we;
  logic [31:0] mreq_data;
  logic [3:0]  mreq_be;
  logic        mreq_valid;
  logic        mreq_ready = 1'b0;
  logic [31:0] mresp_data = '0;
  logic        mresp_valid = 1'b0;
  logic        mresp_ready;
  logic [2:0]  outstanding;
  logic        err;

  mem_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .REQ_DEPTH(2), .RESP_DEPTH(4), .WRITE_RESP(0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .up_req_addr(req_addr), .up_req_we(req_we), .up_req_data(req_data),
    .up_req_be(req_be), .up_req_valid(req_valid), .up_req_ready(req_ready),
    .up_resp_data(resp_data), .up_resp_valid(resp_valid), .up_resp_ready(resp_rdy),
    .mem_req_addr(mreq_addr), .mem_req_we(mreq_we), .mem_req_data(mreq_data),
    .mem_req_be(mreq_be), .mem_req_valid(mreq_valid), .mem_req_ready(mreq_ready),
    .mem_resp_data(mresp_data), .mem_resp_valid(mresp_valid), .mem_resp_ready(mresp_ready),
    .outstanding(outstanding), .err(err)
  );

  // Second DUT (WRITE_RESP = 1)
  logic [31:0] w_req_addr = '0;
  logic        w_req_we = 1'b0;
  logic [31:0] w_req_data = '0;
  logic [3:0]  w_req_be = '0;
  logic        w_req_valid = 1'b0;
  logic        w_req_ready;
  logic [31:0] w_resp_data;
  logic        w_resp_valid;
  logic        w_resp_rdy = 1'b0;
  logic [31:0] w_mreq_addr;
  logic        w_mreq_we;
  logic [31:0] w_mreq_data;
  logic [3:0]  w_mreq_be;
  logic        w_mreq_valid;
  logic        w_mreq_ready = 1'b0;
  logic [31:0] w_mresp_data = '0;
  logic        w_mresp_valid = 1'b0;
  logic        w_mresp_ready;
  logic [2:0]  w_outstanding;
  logic        w_err;

  mem_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .REQ_DEPTH(2), .RESP_DEPTH(4), .WRITE_RESP(1)
  ) u_dut_wr (
    .clk(clk), .rst(rst),
    .up_req_addr(w_req_addr), .up_req_we(w_req_we), .up_req_data(w_req_data),
    .up_req_be(w_req_be), .up_req_valid(w_req_valid), .up_req_ready(w_req_ready),
    .up_resp_data(w_resp_data), .up_resp_valid(w_resp_valid), .up_resp_ready(w_resp_rdy),
    .mem_req_addr(w_mreq_addr), .mem_req_we(w_mreq_we), .mem_req_data(w_mreq_data),
    .mem_req_be(w_mreq_be), .mem_req_valid(w_mreq_valid), .mem_req_ready(w_mreq_ready),
    .mem_resp_data(w_mresp_data), .mem_resp_valid(w_mresp_valid), .mem_resp_ready(w_mresp_ready),
    .outstanding(w_outstanding), .err(w_err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  int issued_cnt = 0;
  int resp_cnt   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change at the falling edge only
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_req(input logic [31:0] a, input logic we, input logic [31:0] d);
    req_addr = a; req_we = we; req_data = d; req_be = 4'hF; req_valid = 1'b1;
    for (int i = 0; i < 50 && !req_ready; i++) step();
    check("req_accept_bound", 32'(req_ready), 1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic mem_respond(input logic [31:0] d);
    mresp_data = d; mresp_valid = 1'b1;
    for (int i = 0; i < 50 && !mresp_ready; i++) step();
    check("resp_accept_bound", 32'(mresp_ready), 1);
    step();
    mresp_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    check("drain", 32'(exp_q.size()), 0);
  endtask

  // Monitor: samples 1 time unit after the falling edge, when the inputs for
  // the next rising edge are already settled.
  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      if (mreq_valid && mreq_ready) issued_cnt++;
      if (resp_valid && resp_rdy) begin
        resp_cnt++;
        check("resp_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("resp_data", resp_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  logic [31:0] w_addrs [3] = '{32'h700, 32'h704, 32'h708};
  logic        w_wes   [3] = '{1'b0, 1'b1, 1'b0};

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    step(); step();
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_mreq_valid", 32'(mreq_valid), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_mresp_ready", 32'(mresp_ready), 0);
    check("rst_outstanding", 32'(outstanding), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b1;
    #1;
    check("rel_req_ready", 32'(req_ready), 1);
    check("rel_mresp_ready", 32'(mresp_ready), 1);
    step();

    // Single read
    mreq_ready = 1'b1;
    exp_q.push_back(32'hDEADBEEF);
    check("t1_pre_mreq_valid", 32'(mreq_valid), 0);
    send_req(32'h100, 1'b0, 32'h0);
    check("t1_mreq_valid", 32'(mreq_valid), 1);
    check("t1_mreq_addr", mreq_addr, 32'h100);
    check("t1_mreq_we", 32'(mreq_we), 0);
    check("t1_out0", 32'(outstanding), 0);
    step();
    check("t1_out1", 32'(outstanding), 1);
    check("t1_issued", 32'(issued_cnt), 1);
    check("t1_mreq_idle", 32'(mreq_valid), 0);
    step(); step();
    check("t1_no_resp_yet", 32'(resp_valid), 0);
    mem_respond(32'hDEADBEEF);
    check("t1_out_back0", 32'(outstanding), 0);
    check("t1_resp_valid", 32'(resp_valid), 1);
    check("t1_resp_data", resp_data, 32'hDEADBEEF);
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    check("t1_resp_gone", 32'(resp_valid), 0);
    check("t1_q_empty", 32'(exp_q.size()), 0);

    // Credit stall: 6 reads, up_resp_ready low
    issued_cnt = 0;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'hA0 + 32'(i));
    for (int i = 0; i < 6; i++) send_req(32'h200 + 32'(4 * i), 1'b0, 32'h0);
    check("t2_out4", 32'(outstanding), 4);
    check("t2_issued4", 32'(issued_cnt), 4);
    check("t2_stalled", 32'(mreq_valid), 0);
    check("t2_req_full", 32'(req_ready), 0);
    check("t2_head", mreq_addr, 32'h210);
    step(); step();
    check("t2_still_issued4", 32'(issued_cnt), 4);
    mem_respond(32'hA0);
    check("t2_out3", 32'(outstanding), 3);
    check("t2_buffered_blocks", 32'(mreq_valid), 0);
    check("t2_resp_head", resp_data, 32'hA0);
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    check("t2_one_credit", 32'(mreq_valid), 1);
    step();
    check("t2_issued5", 32'(issued_cnt), 5);
    check("t2_out4_again", 32'(outstanding), 4);
    check("t2_stalled_again", 32'(mreq_valid), 0);
    check("t2_head5", mreq_addr, 32'h214);
    resp_rdy = 1'b1;
    for (int k = 1; k < 6; k++) mem_respond(32'hA0 + 32'(k));
    wait_drain();
    check("t2_issued6", 32'(issued_cnt), 6);
    check("t2_out_end", 32'(outstanding), 0);

    // Write bypasses the credit check
    issued_cnt = 0;
    resp_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_req(32'h300 + 32'(4 * i), 1'b0, 32'h0);
    step();
    check("t3_out4", 32'(outstanding), 4);
    send_req(32'h400, 1'b1, 32'h12345678);
    check("t3_wr_valid", 32'(mreq_valid), 1);
    check("t3_wr_we", 32'(mreq_we), 1);
    check("t3_wr_addr", mreq_addr, 32'h400);
    check("t3_wr_data", mreq_data, 32'h12345678);
    check("t3_wr_be", 32'(mreq_be), 32'hF);
    step();
    check("t3_issued5", 32'(issued_cnt), 5);
    check("t3_out_still4", 32'(outstanding), 4);
    resp_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(32'hB0 + 32'(k));
      mem_respond(32'hB0 + 32'(k));
    end
    wait_drain();

    // Read / write / read, WRITE_RESP = 0: two responses
    resp_cnt = 0;
    exp_q.push_back(32'hC0);
    exp_q.push_back(32'hC1);
    send_req(32'h600, 1'b0, 32'h0);
    send_req(32'h604, 1'b1, 32'h55AA55AA);
    send_req(32'h608, 1'b0, 32'h0);
    step(); step();
    check("t4_out2", 32'(outstanding), 2);
    mem_respond(32'hC0);
    mem_respond(32'hC1);
    wait_drain();
    check("t4_resp_cnt", 32'(resp_cnt), 2);
    check("t4_out0", 32'(outstanding), 0);
    check("t4_err0", 32'(err), 0);

    // Read / write / read, WRITE_RESP = 1: three responses
    w_mreq_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      w_req_addr = w_addrs[i]; w_req_we = w_wes[i]; w_req_data = 32'h0BAD0000 + 32'(i);
      w_req_be = 4'hF; w_req_valid = 1'b1;
      check("w_req_ready", 32'(w_req_ready), 1);
      step();
    end
    w_req_valid = 1'b0;
    step(); step();
    check("w_out3", 32'(w_outstanding), 3);
    for (int i = 0; i < 3; i++) begin
      w_mresp_data = 32'hC100 + 32'(i); w_mresp_valid = 1'b1;
      step();
    end
    w_mresp_valid = 1'b0;
    check("w_out0", 32'(w_outstanding), 0);
    for (int i = 0; i < 3; i++) begin
      check("w_resp_valid", 32'(w_resp_valid), 1);
      check("w_resp_data", w_resp_data, 32'hC100 + 32'(i));
      w_resp_rdy = 1'b1;
      step();
      w_resp_rdy = 1'b0;
    end
    check("w_resp_done", 32'(w_resp_valid), 0);
    check("w_err0", 32'(w_err), 0);

    // Stray response
    mem_respond(32'h00000BAD);
    check("t5_err", 32'(err), 1);
    check("t5_out0", 32'(outstanding), 0);
    check("t5_no_resp", 32'(resp_valid), 0);
    step(); step(); step();
    check("t5_err_sticky", 32'(err), 1);
    check("t5_still_no_resp", 32'(resp_valid), 0);

    // Issue and response in the same cycle at outstanding = 2
    resp_rdy = 1'b0;
    issued_cnt = 0;
    send_req(32'h800, 1'b0, 32'h0);
    send_req(32'h804, 1'b0, 32'h0);
    step();
    check("t6_out2", 32'(outstanding), 2);
    mreq_ready = 1'b0;
    send_req(32'h808, 1'b0, 32'h0);
    check("t6_head_valid", 32'(mreq_valid), 1);
    mreq_ready = 1'b1;
    mresp_data = 32'hE0; mresp_valid = 1'b1;
    step();
    mresp_valid = 1'b0;
    mreq_ready = 1'b0;
    check("t6_out_hold2", 32'(outstanding), 2);
    check("t6_issued3", 32'(issued_cnt), 3);
    check("t6_buffered", 32'(resp_valid), 1);

    // Mid-transaction reset: 2 outstanding, 1 buffered response, 1 queued request
    send_req(32'h900, 1'b0, 32'h0);
    check("t7_pre_mreq_valid", 32'(mreq_valid), 1);
    #2;
    rst = 1'b0;
    #1;
    check("t7_req_ready", 32'(req_ready), 0);
    check("t7_mreq_valid", 32'(mreq_valid), 0);
    check("t7_resp_valid", 32'(resp_valid), 0);
    check("t7_mresp_ready", 32'(mresp_ready), 0);
    check("t7_out", 32'(outstanding), 0);
    check("t7_err", 32'(err), 0);
    step(); step();
    rst = 1'b1;
    #1;
    check("t7_rel_req_ready", 32'(req_ready), 1);
    check("t7_rel_mresp_ready", 32'(mresp_ready), 1);
    check("t7_rel_mreq_valid", 32'(mreq_valid), 0);
    check("t7_rel_resp_valid", 32'(resp_valid), 0);
    step();
    mreq_ready = 1'b1;
    resp_rdy = 1'b1;
    exp_q.push_back(32'hF00D);
    send_req(32'hA00, 1'b0, 32'h0);
    check("t7_new_addr", mreq_addr, 32'hA00);
    step();
    check("t7_new_out1", 32'(outstanding), 1);
    mem_respond(32'hF00D);
    wait_drain();
    check("t7_new_out0", 32'(outstanding), 0);
    check("t7_new_err0", 32'(err), 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
